// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, per-sweep debounce FSM and
// single-entry event register with ack/overrun. Define KEYPAD_TYPEMATIC_EN for auto-repeat.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DLY     = 125,
    parameter int unsigned REPEAT_RATE    = 25
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    input  logic       i_key_ack,
    output logic       o_key_held,
    output logic       o_overrun
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DbW  = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]  DbTarget = DbW'(DEBOUNCE_SCANS);
    localparam logic [DbW-1:0]  DbOne    = DbW'(1);

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RepW   = (RepMax > 0) ? $clog2(RepMax + 1) : 1;
    localparam logic [RepW-1:0] RepDly  = RepW'(REPEAT_DLY);
    localparam logic [RepW-1:0] RepRate = RepW'(REPEAT_RATE);
`else
    localparam int unsigned unused_repeat_cfg = REPEAT_DLY + REPEAT_RATE;
`endif

    typedef enum logic [1:0] {StIdle, StPressDb, StPressed, StReleaseDb} state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [1:0]      acc_n_q, acc_n_d;
    logic [3:0]      acc_code_q, acc_code_d;
    state_e          state_q, state_d;
    logic [3:0]      cand_code_q, cand_code_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            valid_q, valid_d;
    logic [3:0]      code_q, code_d;
    logic            overrun_q, overrun_d;
`ifdef KEYPAD_TYPEMATIC_EN
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic            rep_first_q, rep_first_d;
`endif

    logic       tick, sweep_done, sweep_single, match, evt, ovr_new;
    logic [3:0] hit, sweep_code;
    logic [2:0] col_n;
    logic [1:0] col_row, sum_n;
    logic [3:0] sum_code;
    logic [DbW-1:0] db_inc;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return 4'hE;
            4'hD: return 4'h0;
            4'hE: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    // Scan timing and per-sweep accumulation; two or more hits in a sweep saturate at 2.
    always_comb begin
        hit     = ~row_sync_q;
        col_n   = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
        col_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) col_row = 2'(i);
        end
        sum_n    = acc_n_q;
        sum_code = acc_code_q;
        if (col_n == 3'd1) begin
            if (acc_n_q == 2'd0) begin
                sum_n    = 2'd1;
                sum_code = key_map(col_row, col_idx_q);
            end else begin
                sum_n = 2'd2;
            end
        end else if (col_n > 3'd1) begin
            sum_n = 2'd2;
        end

        tick         = (cnt_q == CntLast);
        sweep_done   = tick && (col_idx_q == 2'd3);
        sweep_single = (sum_n == 2'd1);
        sweep_code   = sum_code;

        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        col_idx_d  = tick ? col_idx_q + 2'd1 : col_idx_q;
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        if (tick) begin
            acc_n_d    = sweep_done ? 2'd0 : sum_n;
            acc_code_d = sweep_done ? 4'h0 : sum_code;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            acc_n_q     <= 2'd0;
            acc_code_q  <= 4'h0;
            state_q     <= StIdle;
            cand_code_q <= 4'h0;
            db_cnt_q    <= '0;
            valid_q     <= 1'b0;
            code_q      <= 4'h0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            row_meta_q  <= i_row;
            row_sync_q  <= row_meta_q;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_code_q <= cand_code_d;
            db_cnt_q    <= db_cnt_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    // Debounce FSM, evaluated only on the cycle a sweep completes.
    always_comb begin
        state_d     = state_q;
        cand_code_d = cand_code_q;
        db_cnt_d    = db_cnt_q;
        evt         = 1'b0;
        match       = sweep_single && (sweep_code == cand_code_q);
        db_inc      = db_cnt_q + 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
        rep_inc     = rep_cnt_q + 1'b1;
        rep_cnt_d   = (state_q == StPressed) ? rep_cnt_q : '0;
        rep_first_d = (state_q == StPressed) ? rep_first_q : 1'b1;
`endif
        if (sweep_done) begin
            unique case (state_q)
                StIdle: begin
                    if (sweep_single) begin
                        cand_code_d = sweep_code;
                        if (DbOne >= DbTarget) begin
                            state_d  = StPressed;
                            db_cnt_d = '0;
                            evt      = 1'b1;
                        end else begin
                            state_d  = StPressDb;
                            db_cnt_d = DbOne;
                        end
                    end
                end
                StPressDb: begin
                    if (!match) begin
                        state_d  = StIdle;
                        db_cnt_d = '0;
                    end else if (db_inc >= DbTarget) begin
                        state_d  = StPressed;
                        db_cnt_d = '0;
                        evt      = 1'b1;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                StPressed: begin
                    if (!match) begin
                        state_d  = (DbOne >= DbTarget) ? StIdle : StReleaseDb;
                        db_cnt_d = (DbOne >= DbTarget) ? '0 : DbOne;
                    end else begin
`ifdef KEYPAD_TYPEMATIC_EN
                        if (rep_inc == (rep_first_q ? RepDly : RepRate)) begin
                            evt         = 1'b1;
                            rep_cnt_d   = '0;
                            rep_first_d = 1'b0;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
`endif
                    end
                end
                StReleaseDb: begin
                    if (match) begin
                        state_d  = StPressed;
                        db_cnt_d = '0;
                    end else if (db_inc >= DbTarget) begin
                        state_d  = StIdle;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Event register: an event that collides with an unacked one is dropped and flagged.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovr_new = 1'b0;
        if (evt) begin
            if (valid_q && !i_key_ack) begin
                ovr_new = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = cand_code_d;
            end
        end else if (valid_q && i_key_ack) begin
            valid_d = 1'b0;
        end
        overrun_d = ovr_new | (overrun_q & ~i_key_ack);
    end

    always_comb begin
        o_col       = ~(4'b0001 << col_idx_q);
        o_key_held  = (state_q == StPressed) || (state_q == StReleaseDb);
        o_key_valid = valid_q;
        o_key_code  = code_q;
        o_overrun   = overrun_q;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning i_clk cycles per column slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full sweeps required to accept a press or release.
REQ-003 SHALL have parameter REPEAT_DLY, default 125, meaning sweeps held before the first repeat (KEYPAD_TYPEMATIC_EN only).
REQ-004 SHALL have parameter REPEAT_RATE, default 25, meaning sweeps between repeats (KEYPAD_TYPEMATIC_EN only).
REQ-005 i_clk  in  1  sole clock.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_row  in  4  raw keypad rows, active-low, asynchronous to i_clk.
REQ-008 o_col  out  4  column drive, active-low, exactly one bit low.
REQ-009 o_key_code  out  4  hex code of the accepted key.
REQ-010 o_key_valid  out  1  event available.
REQ-011 i_key_ack  in  1  consumer accepts the event.
REQ-012 o_key_held  out  1  debounced key-down level.
REQ-013 o_overrun  out  1  sticky flag: event dropped.

Function
REQ-014 i_row SHALL pass through a 2-flop synchroniser before any use.
REQ-015 A slot counter SHALL count 0..SCAN_DIV-1; the terminal count is the slot tick.
REQ-016 On each slot tick: synchronised rows sampled for the current column, then column index advances 0->1->2->3->0; o_col = ~(1<<index).
REQ-017 After column 3 is sampled, one sweep completes; sweep result = single key, none, or multiple (multiple SHALL be treated as none).
REQ-018 Code map, row r / col c: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-019 FSM states IDLE, PRESS_DB, PRESSED, RELEASE_DB; evaluated once per sweep.
REQ-020 IDLE -> PRESS_DB on single-key result; candidate code latched, stable count = 1.
REQ-021 PRESS_DB: same code increments count; a different result returns to IDLE; count reaching DEBOUNCE_SCANS -> PRESSED and emits one event.
REQ-022 PRESSED -> RELEASE_DB on any result other than the latched code.
REQ-023 RELEASE_DB: DEBOUNCE_SCANS consecutive non-matching sweeps -> IDLE; a matching sweep -> PRESSED with no new event.
REQ-024 o_key_held SHALL be high in PRESSED and RELEASE_DB.
REQ-025 Event: o_key_valid rises the cycle after the accepting sweep; o_key_code loaded that same cycle and stable while valid.
REQ-026 Handshake: i_key_ack while o_key_valid high clears valid next cycle; ack while valid low SHALL be ignored.
REQ-027 New event while valid high and unacked: event dropped, code unchanged, o_overrun set.
REQ-028 New event in the same cycle as ack: new code loaded, valid stays high, no overrun.
REQ-029 o_overrun clears only on a cycle with i_key_ack high and no new overrun.

Reset
REQ-030 On i_rst high: FSM IDLE, counters 0, column index 0, o_col = 4'b1110, o_key_valid 0, o_key_code 0, o_key_held 0, o_overrun 0, synchroniser flops = 4'b1111.
REQ-031 Reset mid-sweep or mid-event SHALL discard all pending state; no event is emitted on release of reset.

Configuration
REQ-032 Macro KEYPAD_TYPEMATIC_EN defined: in PRESSED, first repeat event after REPEAT_DLY sweeps, then every REPEAT_RATE sweeps, same code, subject to REQ-025..REQ-029.
REQ-033 Macro undefined: exactly one event per debounced press; repeat counters and parameters SHALL have no effect.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_DLY=3, REPEAT_RATE=2)
REQ-034 Reset pulse mid-scan -> o_col=1110, all outputs 0 next cycle; columns then rotate 1110,1101,1011,0111 every 4 cycles.
REQ-035 Hold row2 low while col1 driven, 3 sweeps -> o_key_valid high with o_key_code=8 after 2nd sweep; ack -> valid low next cycle; release -> o_key_held low after 2 clean sweeps.
REQ-036 1-sweep glitch on row0/col3 -> no event, FSM back to IDLE.
REQ-037 Two keys (r0c0 + r1c1) held -> no event, o_key_held stays 0.
REQ-038 Press '5', no ack, release, press '9' -> code stays 5, o_overrun=1; ack clears both; ack coincident with '9' event -> code=9, valid high, overrun 0.
REQ-039 KEYPAD_TYPEMATIC_EN, hold '0' with ack each event -> events at sweeps 2, 5, 7, 9; macro undefined -> single event only.
